// File: rtl/down_ctr_seq.sv
// Loadable down-counter sequenced by a small FSM (IDLE/ARMED/RUN/HOLD/DONE).
// Define DOWN_CTR_AUTO_RELOAD_EN for periodic mode: terminal count reloads and keeps running.
module down_ctr_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_q_zero;
  logic [WIDTH-1:0] w_q_dec;

  assign w_q_zero = (r_q == '0);
  assign w_q_dec  = r_q - WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_q      <= w_q_next;
      r_reload <= w_reload_next;
      r_done   <= w_done_next;
    end
  end

  // Priority is abort > load > pause > start; load/start are ignored in RUN and HOLD.
  always_comb begin
    w_state_next  = r_state;
    w_q_next      = r_q;
    w_reload_next = r_reload;
    w_done_next   = 1'b0;
    if (abort) begin
      w_state_next = S_IDLE;
      w_q_next     = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (load) begin
            w_state_next  = S_ARMED;
            w_q_next      = load_val;
            w_reload_next = load_val;
          end
        end
        S_ARMED: begin
          if (load) begin
            w_q_next      = load_val;
            w_reload_next = load_val;
          end else if (start && !pause) begin
            w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (pause) begin
            w_state_next = S_HOLD;
          end else if (w_q_zero) begin
            // Zero is checked before decrementing, so the count never wraps.
            w_done_next = 1'b1;
`ifdef DOWN_CTR_AUTO_RELOAD_EN
            w_q_next     = r_reload;
`else
            w_state_next = S_DONE;
`endif
          end else begin
            w_q_next = w_q_dec;
          end
        end
        S_HOLD: begin
          if (!pause) begin
            w_state_next = S_RUN;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_q_next     = '0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_qb
      assign qb[gi] = ~r_q[gi];
    end
  endgenerate

  assign q     = r_q;
  assign busy  = (r_state == S_RUN) || (r_state == S_HOLD);
  assign done  = r_done;
  assign state = r_state;

endmodule

// File: tb/tb_down_ctr_seq.sv
// Directed bench for down_ctr_seq; covers the default build, or periodic mode when
// DOWN_CTR_AUTO_RELOAD_EN is defined.
module tb_down_ctr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] load_val;
  logic       load, start, pause, abort;
  logic [3:0] q, qb;
  logic       busy, done;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;
  logic [3:0] eq;
  logic       ed;

  down_ctr_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .load_val(load_val), .load(load), .start(start),
    .pause(pause), .abort(abort), .q(q), .qb(qb), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    load = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    load_val = 4'd5;
    rst = 1'b0;
    #2;
    tests++;
    if ({state, q, qb, busy, done} !== {3'd0, 4'd0, 4'hF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values got state=%0d q=%0d qb=%h busy=%b done=%b want 0/0/f/0/0", state, q, qb, busy, done);
    end
    load = 1'b1;
    tick();
    tests++;
    if ({state, q} !== {3'd0, 4'd0}) begin
      fails++;
      $display("FAIL reset_holds got state=%0d q=%0d want state=0 q=0", state, q);
    end
    #3 rst = 1'b1;
    tick();
    load = 1'b0;
    tests++;
    if ({state, q, busy} !== {3'd1, 4'd5, 1'b0}) begin
      fails++;
      $display("FAIL first_edge_after_reset got state=%0d q=%0d busy=%b want state=1 q=5 busy=0", state, q, busy);
    end
  endtask

  task automatic test_countdown;
    idle_inputs();
    load_val = 4'd5; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      eq = 4'(i);
      tests++;
      if ({state, q, qb, busy, done} !== {3'd2, eq, ~eq, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL countdown_run got state=%0d q=%0d qb=%h busy=%b done=%b want state=2 q=%0d", state, q, qb, busy, done, eq);
      end
      tick();
    end
    tests++;
    if ({state, q, qb, busy, done} !== {3'd4, 4'd0, 4'hF, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL countdown_done got state=%0d q=%0d qb=%h busy=%b done=%b want 4/0/f/0/1", state, q, qb, busy, done);
    end
    start = 1'b1;
    tick();
    tests++;
    if ({state, q, busy, done} !== {3'd4, 4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL done_pulse_and_start_ignored got state=%0d q=%0d busy=%b done=%b want 4/0/0/0", state, q, busy, done);
    end
    start = 1'b0;
  endtask

  task automatic test_zero_load;
    idle_inputs();
    load_val = 4'd0; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if ({state, q, busy, done} !== {3'd2, 4'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL zero_load_run got state=%0d q=%0d busy=%b done=%b want 2/0/1/0", state, q, busy, done);
    end
    tick();
    tests++;
    if ({state, q, done} !== {3'd4, 4'd0, 1'b1}) begin
      fails++;
      $display("FAIL zero_load_done got state=%0d q=%0d done=%b want 4/0/1", state, q, done);
    end
  endtask

  task automatic test_pause;
    idle_inputs();
    load_val = 4'd6; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    tests++;
    if ({state, q} !== {3'd2, 4'd3}) begin
      fails++;
      $display("FAIL pause_setup got state=%0d q=%0d want state=2 q=3", state, q);
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // load/start on the middle hold cycle must have no effect
      load = (i == 1); start = (i == 1); load_val = 4'd9;
      tick();
      tests++;
      if ({state, q, busy, done} !== {3'd3, 4'd3, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL pause_hold cycle=%0d got state=%0d q=%0d busy=%b done=%b want 3/3/1/0", i, state, q, busy, done);
      end
    end
    idle_inputs();
    tick();
    tests++;
    if ({state, q} !== {3'd2, 4'd3}) begin
      fails++;
      $display("FAIL pause_resume got state=%0d q=%0d want state=2 q=3", state, q);
    end
    for (int i = 2; i >= 0; i--) begin
      tick();
      eq = 4'(i);
      tests++;
      if ({state, q, done} !== {3'd2, eq, 1'b0}) begin
        fails++;
        $display("FAIL pause_count got state=%0d q=%0d done=%b want state=2 q=%0d", state, q, done, eq);
      end
    end
    tick();
    tests++;
    if ({state, done} !== {3'd4, 1'b1}) begin
      fails++;
      $display("FAIL pause_done got state=%0d done=%b want state=4 done=1", state, done);
    end
  endtask

  task automatic test_abort;
    idle_inputs();
    load_val = 4'd9; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0;
    tests++;
    if ({state, q} !== {3'd2, 4'd8}) begin
      fails++;
      $display("FAIL load_ignored_in_run got state=%0d q=%0d want state=2 q=8", state, q);
    end
    tick(); tick(); tick(); tick();
    tests++;
    if (q !== 4'd4) begin
      fails++;
      $display("FAIL abort_setup got q=%0d want 4", q);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({state, q, qb, busy, done} !== {3'd0, 4'd0, 4'hF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_idle got state=%0d q=%0d qb=%h busy=%b done=%b want 0/0/f/0/0", state, q, qb, busy, done);
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({state, q, done} !== {3'd0, 4'd0, 1'b0}) begin
        fails++;
        $display("FAIL start_after_abort cycle=%0d got state=%0d q=%0d done=%b want 0/0/0", i, state, q, done);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_priority;
    idle_inputs();
    load_val = 4'd3; load = 1'b1;
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    idle_inputs();
    tests++;
    if ({state, q} !== {3'd0, 4'd0}) begin
      fails++;
      $display("FAIL abort_beats_load_start got state=%0d q=%0d want state=0 q=0", state, q);
    end
    load = 1'b1;
    tick();
    load_val = 4'd7; pause = 1'b1;
    tick();
    tests++;
    if ({state, q} !== {3'd1, 4'd7}) begin
      fails++;
      $display("FAIL load_beats_pause got state=%0d q=%0d want state=1 q=7", state, q);
    end
    load = 1'b0; start = 1'b1;
    tick();
    tests++;
    if ({state, q} !== {3'd1, 4'd7}) begin
      fails++;
      $display("FAIL pause_beats_start got state=%0d q=%0d want state=1 q=7", state, q);
    end
    pause = 1'b0;
    tick();
    start = 1'b0;
    tests++;
    if ({state, q, busy} !== {3'd2, 4'd7, 1'b1}) begin
      fails++;
      $display("FAIL start_to_run got state=%0d q=%0d busy=%b want 2/7/1", state, q, busy);
    end
  endtask

  task automatic test_async_reset;
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({state, q, qb, busy, done} !== {3'd0, 4'd0, 4'hF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset got state=%0d q=%0d qb=%h busy=%b done=%b want 0/0/f/0/0", state, q, qb, busy, done);
    end
    tick();
    #3 rst = 1'b1;
    tick();
    tests++;
    if ({state, q, done} !== {3'd0, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL after_async_reset got state=%0d q=%0d done=%b want 0/0/0", state, q, done);
    end
  endtask

  task automatic test_auto_reload;
    idle_inputs();
    load_val = 4'd2; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      eq = 4'(2 - (k % 3));
      ed = ((k % 3) == 0);
      tests++;
      if ({state, q, qb, busy, done} !== {3'd2, eq, ~eq, 1'b1, ed}) begin
        fails++;
        $display("FAIL auto_reload step=%0d got state=%0d q=%0d busy=%b done=%b want state=2 q=%0d done=%b", k, state, q, busy, done, eq, ed);
      end
    end
    pause = 1'b1;
    tick();
    tests++;
    if ({state, q} !== {3'd3, 4'd1}) begin
      fails++;
      $display("FAIL auto_pause got state=%0d q=%0d want state=3 q=1", state, q);
    end
    pause = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({state, q, done} !== {3'd0, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL auto_abort got state=%0d q=%0d done=%b want 0/0/0", state, q, done);
    end
  endtask

  task automatic test_auto_zero;
    idle_inputs();
    load_val = 4'd0; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if ({state, q, done} !== {3'd2, 4'd0, 1'b1}) begin
        fails++;
        $display("FAIL auto_zero step=%0d got state=%0d q=%0d done=%b want 2/0/1", k, state, q, done);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef DOWN_CTR_AUTO_RELOAD_EN
    test_auto_reload();
    test_auto_zero();
    test_priority();
`else
    test_countdown();
    test_zero_load();
    test_pause();
    test_abort();
    test_priority();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/down_ctr_seq.md
DOWN_CTR_SEQ -- requirements
Module: down_ctr_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port load_val, input, WIDTH bits: terminal start value for the countdown.
REQ-005 The block SHALL have port load, input, 1 bit: capture load_val into the counter and reload register.
REQ-006 The block SHALL have port start, input, 1 bit: begin counting from the loaded value.
REQ-007 The block SHALL have port pause, input, 1 bit: level; freezes the count while high.
REQ-008 The block SHALL have port abort, input, 1 bit: return to idle and clear the count.
REQ-009 The block SHALL have port q, output, WIDTH bits: current count.
REQ-010 The block SHALL have port qb, output, WIDTH bits: bitwise complement of q at all times.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN or HOLD.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse on terminal count.
REQ-013 The block SHALL have port state, output, 3 bits: FSM state (IDLE=0, ARMED=1, RUN=2, HOLD=3, DONE=4).

Function
REQ-014 The FSM SHALL move from IDLE or DONE to ARMED on load, with q <= load_val and reload register <= load_val at that edge.
REQ-015 In ARMED, load SHALL re-capture load_val and stay ARMED; start SHALL move to RUN with q unchanged.
REQ-016 In RUN, each edge SHALL do q <= q-1 if q != 0; if q == 0, go to DONE and register done=1 for exactly one cycle.
REQ-017 Load N then start: q SHALL show N, N-1, ..., 0 on successive edges in RUN, with done high in the cycle after the edge that samples q==0 (N+1 edges after entering RUN).
REQ-018 load_val == 0 SHALL be legal: RUN lasts one edge, then DONE with a done pulse.
REQ-019 In RUN, pause high SHALL move to HOLD with q frozen; in HOLD, pause low SHALL return to RUN with counting resuming on the next edge.
REQ-020 In RUN or HOLD, load and start SHALL be ignored.
REQ-021 In DONE, q SHALL hold 0, busy SHALL be 0, and start SHALL be ignored; only load or abort exit DONE.
REQ-022 abort SHALL force IDLE and q=0 in any state, with done=0 in the following cycle.
REQ-023 Simultaneous inputs SHALL resolve with priority abort > load > pause > start.
REQ-024 Decrement SHALL be modulo 2^WIDTH; q SHALL never wrap below 0 in RUN (the zero check precedes the decrement).

Reset
REQ-025 While rst=0, regardless of clk: state=IDLE, q=0, qb=all ones, reload register=0, busy=0, done=0.
REQ-026 Reset asserted mid-count SHALL abandon the count immediately, with no done pulse.
REQ-027 The first active edge after rst rises SHALL evaluate inputs normally.

Configuration
REQ-028 Macro DOWN_CTR_AUTO_RELOAD_EN SHALL select terminal-count behaviour: defined means q==0 in RUN pulses done, loads q <= reload register, and stays in RUN (periodic mode); undefined means the FSM enters DONE per REQ-016.
REQ-029 With DOWN_CTR_AUTO_RELOAD_EN defined, pause and abort SHALL behave as in REQ-019 and REQ-022, and a reload value of 0 SHALL give done on every RUN edge.

Verification
REQ-030 Reset, then load_val=5 with load, then start -> q=5,4,3,2,1,0; done pulses once; state=DONE; busy low; qb=~q at every cycle.
REQ-031 load 6, start, pause high for 3 cycles at q=3 -> q holds 3 with state=HOLD; resume gives 2,1,0 and done.
REQ-032 load 9, start, abort at q=4 -> next cycle q=0, state=IDLE, no done pulse; subsequent start is ignored.
REQ-033 load, start and abort all asserted together in ARMED -> IDLE with q=0; load and pause together in ARMED -> reload, stay ARMED.
REQ-034 rst low asynchronously (not clock-aligned) mid-RUN at q=7 -> q=0 and qb=4'hF before the next edge; no done.
REQ-035 With DOWN_CTR_AUTO_RELOAD_EN defined, load 2 and start -> q=2,1,0,2,1,0,...; done every 3rd cycle; busy stays high.
